// File: rtl/buffer_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : buffer_read_scheduler
// Purpose  : Triple-buffer bank ownership for the matrix frame buffer and
//            in-order (bank, block, addr) read strobe sequencing.
// Revision : 1.0
// ============================================================================
module buffer_read_scheduler #(
    parameter  int BLOCK_DEPTH       = 480,
    parameter  int BANK_COUNT        = 3,
    parameter  int BLOCK_COUNT       = 4,
    parameter  int SPI_CHANNEL_COUNT = 3,
    localparam int BANK_W            = (BANK_COUNT  > 1) ? $clog2(BANK_COUNT)  : 1,
    localparam int BLK_W             = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1,
    localparam int ADDR_W            = (BLOCK_DEPTH > 1) ? $clog2(BLOCK_DEPTH) : 1
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_wr_done,
    output logic [BANK_W-1:0] O_wr_bank,
    input  logic              I_read_next,
    output logic              O_rd_en,
    output logic [BANK_W-1:0] O_rd_bank,
    output logic [BLK_W-1:0]  O_rd_block,
    output logic [ADDR_W-1:0] O_rd_addr,
    output logic              O_frame_start,
    output logic              O_frame_done,
    output logic              O_underrun,
    output logic              O_busy
);

    localparam logic [BLK_W-1:0]  c_blk_last  = BLK_W'(BLOCK_COUNT - 1);
    localparam logic [ADDR_W-1:0] c_addr_last = ADDR_W'(BLOCK_DEPTH - 1);

    generate
        if (BANK_COUNT < 3) begin : g_bank_count_check
            $error("buffer_read_scheduler: BANK_COUNT must be >= 3");
        end
        if (SPI_CHANNEL_COUNT < 1) begin : g_spi_count_check
            $error("buffer_read_scheduler: SPI_CHANNEL_COUNT must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [BANK_W-1:0]   r_wr_bank;
    logic [BANK_W-1:0]   r_rd_bank;
    logic                r_rd_valid;
    logic [BANK_W-1:0]   r_rdy_bank;
    logic                r_rdy_valid;
    logic [BLK_W-1:0]    r_block;
    logic [ADDR_W-1:0]   r_addr;

    logic                r_rd_en;
    logic [BLK_W-1:0]    r_rd_block;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_frame_start;
    logic                r_frame_done;
    logic                r_underrun;

    logic                w_load;
    logic                w_issue;
    logic                w_last;
    logic                w_release;
    logic                w_underrun;
    logic [BANK_W-1:0]   w_rd_bank_nxt;
    logic                w_rd_valid_nxt;
    logic [BANK_W-1:0]   w_wr_bank_nxt;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_issue     = 1'b0;
        w_last      = 1'b0;
        w_release   = 1'b0;
        w_underrun  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_underrun = I_read_next;
                if (r_rdy_valid) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_load      = 1'b1;
                w_underrun  = I_read_next;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (I_read_next) begin
                    w_issue = 1'b1;
                    if (r_block == c_blk_last && r_addr == c_addr_last) begin
                        w_last      = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_release   = 1'b1;
                w_underrun  = I_read_next;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Reader ownership as it will stand after this edge; the writer's next
        // bank must avoid it as well as the bank just completed.
        w_rd_bank_nxt  = w_load ? r_rdy_bank : r_rd_bank;
        w_rd_valid_nxt = w_load ? 1'b1 : (w_release ? 1'b0 : r_rd_valid);

        w_wr_bank_nxt = r_wr_bank;
        for (int b = BANK_COUNT - 1; b >= 0; b--) begin
            if ((BANK_W'(b) != r_wr_bank) &&
                !(w_rd_valid_nxt && (BANK_W'(b) == w_rd_bank_nxt))) begin
                w_wr_bank_nxt = BANK_W'(b);
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            r_wr_bank     <= '0;
            r_rd_bank     <= '0;
            r_rd_valid    <= 1'b0;
            r_rdy_bank    <= '0;
            r_rdy_valid   <= 1'b0;
            r_block       <= '0;
            r_addr        <= '0;
            r_rd_en       <= 1'b0;
            r_rd_block    <= '0;
            r_rd_addr     <= '0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_rd_en       <= w_issue;
            r_frame_start <= w_load;
            r_frame_done  <= w_last;
            r_underrun    <= w_underrun;
            r_rd_bank     <= w_rd_bank_nxt;
            r_rd_valid    <= w_rd_valid_nxt;

            if (w_load) begin
                r_block <= '0;
                r_addr  <= '0;
            end else if (w_issue) begin
                r_rd_block <= r_block;
                r_rd_addr  <= r_addr;
                if (r_block == c_blk_last) begin
                    r_block <= '0;
                    r_addr  <= r_addr + 1'b1;
                end else begin
                    r_block <= r_block + 1'b1;
                end
            end

            // A completed write always wins over the LOAD clearing the ready slot.
            if (I_wr_done) begin
                r_rdy_bank  <= r_wr_bank;
                r_rdy_valid <= 1'b1;
                r_wr_bank   <= w_wr_bank_nxt;
            end else if (w_load) begin
                r_rdy_valid <= 1'b0;
            end
        end
    end

    assign O_wr_bank     = r_wr_bank;
    assign O_rd_en       = r_rd_en;
    assign O_rd_bank     = r_rd_bank;
    assign O_rd_block    = r_rd_block;
    assign O_rd_addr     = r_rd_addr;
    assign O_frame_start = r_frame_start;
    assign O_frame_done  = r_frame_done;
    assign O_underrun    = r_underrun;
    assign O_busy        = (r_state == S_LOAD) || (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_buffer_read_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_buffer_read_scheduler
// Purpose  : Scoreboard bench for buffer_read_scheduler against a frame-level
//            reference model of bank ownership and word ordering.
// Revision : 1.0
// ============================================================================
module tb_buffer_read_scheduler;

    localparam int NB    = 3;
    localparam int BC    = 4;
    localparam int BD    = 480;
    localparam int TOTAL = BC * BD;

    logic       clk;
    logic       I_rst;
    logic       I_wr_done;
    logic       I_read_next;
    logic [1:0] O_wr_bank;
    logic       O_rd_en;
    logic [1:0] O_rd_bank;
    logic [1:0] O_rd_block;
    logic [8:0] O_rd_addr;
    logic       O_frame_start;
    logic       O_frame_done;
    logic       O_underrun;
    logic       O_busy;

    buffer_read_scheduler #(
        .BLOCK_DEPTH       (BD),
        .BANK_COUNT        (NB),
        .BLOCK_COUNT       (BC),
        .SPI_CHANNEL_COUNT (3)
    ) dut (
        .I_clk         (clk),
        .I_rst         (I_rst),
        .I_wr_done     (I_wr_done),
        .O_wr_bank     (O_wr_bank),
        .I_read_next   (I_read_next),
        .O_rd_en       (O_rd_en),
        .O_rd_bank     (O_rd_bank),
        .O_rd_block    (O_rd_block),
        .O_rd_addr     (O_rd_addr),
        .O_frame_start (O_frame_start),
        .O_frame_done  (O_frame_done),
        .O_underrun    (O_underrun),
        .O_busy        (O_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { int cyc; int bank; int blk; int addr; bit last; } rd_t;
    typedef struct { int cyc; int bank; } fs_t;

    rd_t q_rd[$];
    fs_t q_fs[$];
    int  q_un[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: frame phases, word index k, bank ownership sets.
    int m_phase = 0;
    int m_wr    = 0;
    int m_rdy   = 0;
    int m_rd    = 0;
    bit m_rdy_v = 1'b0;
    bit m_rd_v  = 1'b0;
    int m_k     = 0;

    bit rn_s, wd_s;
    int old_wr;
    bit used[NB];
    bit found;

    always @(posedge clk) begin
        cyc = cyc + 1;
        rn_s = I_read_next;
        wd_s = I_wr_done;
        if (I_rst) begin
            m_phase = 0; m_wr = 0; m_rdy = 0; m_rd = 0;
            m_rdy_v = 1'b0; m_rd_v = 1'b0; m_k = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (rn_s) q_un.push_back(cyc);
                    if (m_rdy_v) m_phase = 1;
                end
                1: begin
                    if (rn_s) q_un.push_back(cyc);
                    m_rd = m_rdy; m_rd_v = 1'b1; m_rdy_v = 1'b0; m_k = 0;
                    q_fs.push_back('{cyc, m_rdy});
                    m_phase = 2;
                end
                2: begin
                    if (rn_s) begin
                        q_rd.push_back('{cyc, m_rd, m_k % BC, m_k / BC, (m_k == TOTAL - 1)});
                        m_k = m_k + 1;
                        if (m_k == TOTAL) m_phase = 3;
                    end
                end
                default: begin
                    if (rn_s) q_un.push_back(cyc);
                    m_rd_v = 1'b0;
                    m_phase = 0;
                end
            endcase
            if (wd_s) begin
                old_wr  = m_wr;
                m_rdy   = old_wr;
                m_rdy_v = 1'b1;
                for (int b = 0; b < NB; b++) used[b] = (b == old_wr) || (m_rd_v && b == m_rd);
                found = 1'b0;
                for (int b = 0; b < NB; b++) begin
                    if (!found && !used[b]) begin
                        m_wr  = b;
                        found = 1'b1;
                    end
                end
            end
        end
    end

    rd_t e_rd;
    fs_t e_fs;
    int  e_un;

    always @(negedge clk) begin
        if (O_rd_en === 1'b1) begin
            n_cmp++;
            if (q_rd.size() > 0 && q_rd[0].cyc == cyc) begin
                e_rd = q_rd.pop_front();
                if (O_rd_bank !== 2'(e_rd.bank) || O_rd_block !== 2'(e_rd.blk) ||
                    O_rd_addr !== 9'(e_rd.addr) || O_frame_done !== e_rd.last) begin
                    n_fail++;
                    $display("FAIL rd_strobe cyc=%0d got bank=%0d blk=%0d addr=%0d done=%0b want bank=%0d blk=%0d addr=%0d done=%0b",
                             cyc, O_rd_bank, O_rd_block, O_rd_addr, O_frame_done,
                             e_rd.bank, e_rd.blk, e_rd.addr, e_rd.last);
                end
            end else begin
                n_fail++;
                $display("FAIL rd_unexpected cyc=%0d got rd_en=1 want rd_en=0", cyc);
            end
        end else begin
            if (q_rd.size() > 0 && q_rd[0].cyc <= cyc) begin
                e_rd = q_rd.pop_front();
                n_cmp++; n_fail++;
                $display("FAIL rd_missing cyc=%0d got rd_en=%b want rd_en=1 (blk=%0d addr=%0d)",
                         cyc, O_rd_en, e_rd.blk, e_rd.addr);
            end
            if (O_frame_done !== 1'b0) begin
                n_cmp++; n_fail++;
                $display("FAIL done_without_rd cyc=%0d got frame_done=%b want 0", cyc, O_frame_done);
            end
        end

        if (O_frame_start === 1'b1) begin
            n_cmp++;
            if (q_fs.size() > 0 && q_fs[0].cyc == cyc) begin
                e_fs = q_fs.pop_front();
                if (O_rd_bank !== 2'(e_fs.bank)) begin
                    n_fail++;
                    $display("FAIL frame_start_bank cyc=%0d got %0d want %0d", cyc, O_rd_bank, e_fs.bank);
                end
            end else begin
                n_fail++;
                $display("FAIL frame_start_unexpected cyc=%0d got 1 want 0", cyc);
            end
        end else if (q_fs.size() > 0 && q_fs[0].cyc <= cyc) begin
            e_fs = q_fs.pop_front();
            n_cmp++; n_fail++;
            $display("FAIL frame_start_missing cyc=%0d got %b want 1", cyc, O_frame_start);
        end

        if (O_underrun === 1'b1) begin
            n_cmp++;
            if (q_un.size() > 0 && q_un[0] == cyc) begin
                e_un = q_un.pop_front();
            end else begin
                n_fail++;
                $display("FAIL underrun_unexpected cyc=%0d got 1 want 0", cyc);
            end
        end else if (q_un.size() > 0 && q_un[0] <= cyc) begin
            e_un = q_un.pop_front();
            n_cmp++; n_fail++;
            $display("FAIL underrun_missing cyc=%0d got %b want 1", cyc, O_underrun);
        end

        n_cmp++;
        if (O_wr_bank !== 2'(m_wr)) begin
            n_fail++;
            $display("FAIL wr_bank cyc=%0d got %0d want %0d", cyc, O_wr_bank, m_wr);
        end
        n_cmp++;
        if (O_busy !== (m_phase == 1 || m_phase == 2)) begin
            n_fail++;
            $display("FAIL busy cyc=%0d got %b want %b", cyc, O_busy, (m_phase == 1 || m_phase == 2));
        end
    end

    // Inputs change on the falling edge; each step consumes one rising edge.
    task automatic step(input bit rn, input bit wd);
        I_read_next = rn;
        I_wr_done   = wd;
        @(negedge clk);
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_quiet(input string name);
        n_cmp++;
        if ({O_wr_bank, O_rd_en, O_rd_bank, O_rd_block, O_rd_addr,
             O_frame_start, O_frame_done, O_underrun, O_busy} !== '0) begin
            n_fail++;
            $display("FAIL %s got outputs=%h want all zero", name,
                     {O_wr_bank, O_rd_en, O_rd_bank, O_rd_block, O_rd_addr,
                      O_frame_start, O_frame_done, O_underrun, O_busy});
        end
    endtask

    task automatic wait_frame_start(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1'b0, 1'b0);
            if (O_frame_start === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s got no frame_start within 10 cycles want frame_start", name);
        end
    endtask

    initial begin
        I_rst       = 1'b1;
        I_wr_done   = 1'b0;
        I_read_next = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        I_rst = 1'b0;

        // No frame ready: every request is an underrun.
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
        step(1'b0, 1'b0); step(1'b0, 1'b0);

        // First frame on bank 0, three writes completing mid-read.
        step(1'b0, 1'b1);
        wait_frame_start("frame0_start");
        check_val("frame0_rd_bank", int'(O_rd_bank), 0);
        check_val("frame0_wr_bank", int'(O_wr_bank), 1);
        for (int i = 0; i < TOTAL; i++) begin
            step(1'b1, (i == 100 || i == 700 || i == 1300));
            if (i == 1300) check_val("mid_run_wr_bank", int'(O_wr_bank), 2);
        end

        // Write completes in the claiming cycle.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check_val("claim_frame_start", int'(O_frame_start), 1);
        check_val("claim_rd_bank", int'(O_rd_bank), 1);
        check_val("claim_wr_bank", int'(O_wr_bank), 0);

        // Throttled requests, then back-to-back up to addr 100.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0);
            repeat (6) step(1'b0, 1'b0);
        end
        for (int i = 0; i < 360; i++) step(1'b1, 1'b0);
        check_val("pre_reset_addr", int'(O_rd_addr), 99);

        I_rst = 1'b1;
        step(1'b0, 1'b0);
        check_quiet("mid_frame_reset");
        I_rst = 1'b0;

        for (int i = 0; i < 12000; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0));
        end
        repeat (5) step(1'b0, 1'b0);

        n_cmp++;
        if (q_rd.size() + q_fs.size() + q_un.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending want 0", q_rd.size() + q_fs.size() + q_un.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
